// File: rtl/alu_arb.sv
// Two-requester arbiter sharing one combinational ALU through an IDLE/ISSUE/RESP handshake FSM.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arb (
  input  logic        clk,
  input  logic        resetn,

  input  logic        req0_valid,
  input  logic [11:0] req0_op,
  input  logic [31:0] req0_src1,
  input  logic [31:0] req0_src2,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_result,
  output logic        rsp0_zero,
  input  logic        rsp0_ready,

  input  logic        req1_valid,
  input  logic [11:0] req1_op,
  input  logic [31:0] req1_src1,
  input  logic [31:0] req1_src2,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_result,
  output logic        rsp1_zero,
  input  logic        rsp1_ready,

  output logic [11:0] alu_op,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,

  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_grant;
  logic [11:0] r_op;
  logic [31:0] r_src1;
  logic [31:0] r_src2;
  logic [31:0] r_result;
  logic        r_zero;

  logic        w_idle;
  logic        w_gnt;
  logic        w_accept;
  logic        w_rsp_hs;

  assign w_idle = (r_state == IDLE);

`ifdef ALU_ARB_RR_EN
  logic r_last_grant;

  // On contention, hand the ALU to whoever did not win last time.
  assign w_gnt = (req0_valid && req1_valid) ? ~r_last_grant : ~req0_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_last_grant <= w_gnt;
    end
  end
`else
  assign w_gnt = ~req0_valid;
`endif

  assign req0_ready = w_idle && req0_valid && !w_gnt;
  assign req1_ready = w_idle && req1_valid &&  w_gnt;
  assign w_accept   = req0_ready || req1_ready;

  assign rsp0_valid  = (r_state == RESP) && !r_grant;
  assign rsp1_valid  = (r_state == RESP) &&  r_grant;
  assign rsp0_result = rsp0_valid ? r_result : 32'd0;
  assign rsp1_result = rsp1_valid ? r_result : 32'd0;
  assign rsp0_zero   = rsp0_valid && r_zero;
  assign rsp1_zero   = rsp1_valid && r_zero;
  assign w_rsp_hs    = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  // The ALU only sees operands during ISSUE so it idles at zero otherwise.
  assign alu_op   = (r_state == ISSUE) ? r_op   : 12'h000;
  assign alu_src1 = (r_state == ISSUE) ? r_src1 : 32'd0;
  assign alu_src2 = (r_state == ISSUE) ? r_src2 : 32'd0;

  assign busy = !w_idle;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_grant  <= 1'b0;
      r_op     <= 12'h000;
      r_src1   <= 32'd0;
      r_src2   <= 32'd0;
      r_result <= 32'd0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_grant <= w_gnt;
            r_op    <= w_gnt ? req1_op   : req0_op;
            r_src1  <= w_gnt ? req1_src1 : req0_src1;
            r_src2  <= w_gnt ? req1_src2 : req0_src2;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_result <= alu_result;
          r_zero   <= alu_zero;
          r_state  <= RESP;
        end
        RESP: begin
          if (w_rsp_hs) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arb.sv
// Directed testbench for alu_arb with a small behavioural ALU; expectations follow ALU_ARB_RR_EN.
module tb_alu_arb;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req0_valid, req1_valid;
  logic [11:0] req0_op, req1_op;
  logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero;
  logic        rsp0_ready, rsp1_ready;
  logic [11:0] alu_op;
  logic [31:0] alu_src1, alu_src2;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arb dut (
    .clk         (clk),
    .resetn      (resetn),
    .req0_valid  (req0_valid),
    .req0_op     (req0_op),
    .req0_src1   (req0_src1),
    .req0_src2   (req0_src2),
    .req0_ready  (req0_ready),
    .rsp0_valid  (rsp0_valid),
    .rsp0_result (rsp0_result),
    .rsp0_zero   (rsp0_zero),
    .rsp0_ready  (rsp0_ready),
    .req1_valid  (req1_valid),
    .req1_op     (req1_op),
    .req1_src1   (req1_src1),
    .req1_src2   (req1_src2),
    .req1_ready  (req1_ready),
    .rsp1_valid  (rsp1_valid),
    .rsp1_result (rsp1_result),
    .rsp1_zero   (rsp1_zero),
    .rsp1_ready  (rsp1_ready),
    .alu_op      (alu_op),
    .alu_src1    (alu_src1),
    .alu_src2    (alu_src2),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .busy        (busy)
  );

  // Shared combinational ALU model
  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      12'h001: alu_result = alu_src1 + alu_src2;
      12'h002: alu_result = alu_src1 - alu_src2;
      12'h004: alu_result = {31'd0, ($signed(alu_src1) < $signed(alu_src2))};
      12'h008: alu_result = {31'd0, (alu_src1 < alu_src2)};
      12'h010: alu_result = alu_src1 & alu_src2;
      default: alu_result = 32'd0;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic exp_grant [4];
  logic got_grant [4];
  logic req1_seen;
  int   n_grants;

  initial begin
    resetn     = 1'b0;
    req0_valid = 1'b0; req0_op = 12'h000; req0_src1 = 32'd0; req0_src2 = 32'd0;
    req1_valid = 1'b0; req1_op = 12'h000; req1_src1 = 32'd0; req1_src2 = 32'd0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
`ifdef ALU_ARB_RR_EN
    exp_grant = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_grant = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

    // Reset state
    tick();
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_op", alu_op, 12'h000);
    tick();
    resetn = 1'b1;
    tick();

    // Port 0 add 5+7
    req0_valid = 1'b1; req0_op = 12'h001; req0_src1 = 32'd5; req0_src2 = 32'd7;
    rsp0_ready = 1'b1;
    #1;
    check("add_req0_ready", req0_ready, 1);
    check("add_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    check("add_issue_busy", busy, 1);
    check("add_issue_alu_op", alu_op, 12'h001);
    check("add_issue_alu_src1", alu_src1, 32'd5);
    check("add_issue_alu_src2", alu_src2, 32'd7);
    check("add_issue_rsp0_valid", rsp0_valid, 0);
    check("add_issue_req0_ready", req0_ready, 0);
    tick();
    check("add_rsp0_valid", rsp0_valid, 1);
    check("add_rsp0_result", rsp0_result, 32'd12);
    check("add_rsp0_zero", rsp0_zero, 0);
    check("add_rsp1_valid", rsp1_valid, 0);
    check("add_resp_alu_op", alu_op, 12'h000);
    tick();
    check("add_done_busy", busy, 0);
    check("add_done_rsp0_valid", rsp0_valid, 0);
    check("add_done_rsp0_result", rsp0_result, 0);

    // Port 1 sub 9-9
    req1_valid = 1'b1; req1_op = 12'h002; req1_src1 = 32'd9; req1_src2 = 32'd9;
    rsp1_ready = 1'b1;
    #1;
    check("sub_req1_ready", req1_ready, 1);
    check("sub_req0_ready", req0_ready, 0);
    tick();
    req1_valid = 1'b0;
    check("sub_issue_alu_op", alu_op, 12'h002);
    check("sub_issue_alu_src1", alu_src1, 32'd9);
    tick();
    check("sub_rsp1_valid", rsp1_valid, 1);
    check("sub_rsp1_result", rsp1_result, 0);
    check("sub_rsp1_zero", rsp1_zero, 1);
    check("sub_rsp0_valid", rsp0_valid, 0);
    check("sub_resp_alu_op", alu_op, 12'h000);
    tick();
    check("sub_done_busy", busy, 0);

    // Port 0 slt with backpressure; port 1 waits meanwhile
    req0_valid = 1'b1; req0_op = 12'h004; req0_src1 = 32'hFFFF_FFFF; req0_src2 = 32'd1;
    rsp0_ready = 1'b0;
    #1;
    check("slt_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 12'h001; req1_src1 = 32'd1; req1_src2 = 32'd1;
    #1;
    check("slt_issue_alu_op", alu_op, 12'h004);
    check("slt_issue_req1_ready", req1_ready, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("slt_hold_rsp0_valid", rsp0_valid, 1);
      check("slt_hold_rsp0_result", rsp0_result, 32'd1);
      check("slt_hold_req0_ready", req0_ready, 0);
      check("slt_hold_req1_ready", req1_ready, 0);
      check("slt_hold_busy", busy, 1);
      tick();
    end
    rsp0_ready = 1'b1;
    #1;
    check("slt_release_rsp0_valid", rsp0_valid, 1);
    tick();
    check("slt_after_hs_busy", busy, 0);
    check("slt_after_hs_rsp0_valid", rsp0_valid, 0);
    check("slt_after_hs_req1_ready", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    tick();
    check("wait_rsp1_valid", rsp1_valid, 1);
    check("wait_rsp1_result", rsp1_result, 32'd2);
    tick();
    check("wait_done_busy", busy, 0);

    // Reset during ISSUE drops the transaction
    req0_valid = 1'b1; req0_op = 12'h001; req0_src1 = 32'd3; req0_src2 = 32'd4;
    tick();
    req0_valid = 1'b0;
    check("rstmid_issue_alu_op", alu_op, 12'h001);
    resetn = 1'b0;
    #1;
    check("rstmid_busy", busy, 0);
    check("rstmid_alu_op", alu_op, 12'h000);
    check("rstmid_rsp0_valid", rsp0_valid, 0);
    tick();
    check("rstmid_rsp0_valid_2", rsp0_valid, 0);
    tick();
    resetn = 1'b1;
    tick();
    check("rstmid_after_rsp0_valid", rsp0_valid, 0);
    check("rstmid_after_busy", busy, 0);
    req0_valid = 1'b1;
    #1;
    check("rstmid_new_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    tick();
    check("rstmid_new_rsp0_valid", rsp0_valid, 1);
    check("rstmid_new_rsp0_result", rsp0_result, 32'd7);
    tick();

    // Contention from a fresh reset
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    req0_valid = 1'b1; req0_op = 12'h001; req0_src1 = 32'd1;  req0_src2 = 32'd2;
    req1_valid = 1'b1; req1_op = 12'h001; req1_src1 = 32'd10; req1_src2 = 32'd20;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    n_grants  = 0;
    req1_seen = 1'b0;
    for (int cyc = 0; cyc < 40 && n_grants < 4; cyc++) begin
      #1;
      if (req1_ready) req1_seen = 1'b1;
      if (req0_ready || req1_ready) begin
        check("arb_single_ready", {31'd0, req0_ready & req1_ready}, 0);
        got_grant[n_grants] = req1_ready;
        n_grants++;
      end
      tick();
    end
    check("arb_grant_count", n_grants, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < n_grants) check($sformatf("arb_grant_%0d", i), got_grant[i], exp_grant[i]);
    end
`ifdef ALU_ARB_RR_EN
    check("arb_req1_seen", req1_seen, 1);
`else
    check("arb_req1_seen", req1_seen, 0);
`endif
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
